seq_divider_32: RTL and testbench

Multi-cycle unsigned 32/32 restoring divider, the inverse operation to the team's fast adder/multiplier datapath. Produces one quotient bit per clock. The per-step trial subtraction is done by one CLA_Array_32 instance driven as a subtractor: a = partial remainder, b = ~divisor, cin = 1. Valid/ready handshake on the operand side and on the result side, so it drops into the same execution pipeline as the multiplier.

---
 rtl/seq_divider_32.sv | 184 ++++++++++++++++++
 tb/tb_seq_divider_32.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/seq_divider_32.sv
// Multi-cycle unsigned 32/32 restoring divider, one quotient bit per clock.
// The trial subtraction in every step goes through one CLA_Array_32 used as
// a subtractor (a + ~b + 1). Valid/ready handshake on operands and result.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for operands, in_ready high, last result held on outputs
// CALC  | one restoring step per edge; a zero divisor spends a single cycle
//       | here and leaves with the divide-by-zero result
// DONE  | result presented with out_valid, held until out_ready

module CLA_Array_32 (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin,
   output logic [31:0] sum,
   output logic        cout
);

   logic [31:0] gen;
   logic [31:0] prop;
   logic [7:0]  grp_g;
   logic [7:0]  grp_p;
   logic [8:0]  grp_c;

   assign gen  = a & b;
   assign prop = a ^ b;

   // group generate/propagate for eight 4-bit blocks
   always_comb begin
      grp_g = '0;
      grp_p = '0;
      for (int gi = 0; gi < 8; gi++) begin
         grp_g[gi] = gen[4*gi+3]
                   | (prop[4*gi+3] & gen[4*gi+2])
                   | (prop[4*gi+3] & prop[4*gi+2] & gen[4*gi+1])
                   | (prop[4*gi+3] & prop[4*gi+2] & prop[4*gi+1] & gen[4*gi]);
         grp_p[gi] = &prop[4*gi +: 4];
      end
   end

   // block carries from the group terms, each expanded from cin
   always_comb begin
      logic acc;
      grp_c = '0;
      for (int k = 0; k <= 8; k++) begin
         acc = cin;
         for (int j = 0; j < k; j++) begin
            acc = grp_g[j] | (grp_p[j] & acc);
         end
         grp_c[k] = acc;
      end
   end

   // bit carries inside each block, then the sum bits
   always_comb begin
      logic acc;
      sum = '0;
      for (int gi = 0; gi < 8; gi++) begin
         acc = grp_c[gi];
         for (int bi = 0; bi < 4; bi++) begin
            sum[4*gi+bi] = prop[4*gi+bi] ^ acc;
            acc = gen[4*gi+bi] | (prop[4*gi+bi] & acc);
         end
      end
   end

   assign cout = grp_c[8];

endmodule

module seq_divider_32 #(
   parameter int          WIDTH        = 32,
   parameter logic [31:0] DBZ_QUOTIENT = 32'hFFFF_FFFF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      state;
   logic [31:0] d_reg;
   logic [31:0] q_reg;
   logic [31:0] r_reg;
   logic [4:0]  count;
   logic        zero_div;

   logic [31:0] trial;
   logic [31:0] diff;
   logic        cout;
   logic        sub_ok;
   logic [31:0] r_next;
   logic [31:0] q_next;

   assign trial = {r_reg[30:0], q_reg[31]};

   CLA_Array_32 u_sub (
      .a    (trial),
      .b    (~d_reg),
      .cin  (1'b1),
      .sum  (diff),
      .cout (cout)
   );

   // r_reg[31] set means the shifted value reached 2^32 and so exceeds any
   // 32-bit divisor; diff is still the correct remainder modulo 2^32.
   // Restoring step: keep the difference if the subtraction fits.
   always_comb begin
      sub_ok = r_reg[31] | cout;
      r_next = sub_ok ? diff : trial;
      q_next = {q_reg[30:0], sub_ok};
   end

   // handshake flags decode the state; held low while reset is asserted
   assign in_ready  = rst_n & (state == S_IDLE);
   assign out_valid = rst_n & (state == S_DONE);

   // control FSM, datapath registers and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         d_reg       <= '0;
         q_reg       <= '0;
         r_reg       <= '0;
         count       <= '0;
         zero_div    <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  d_reg    <= divisor;
                  q_reg    <= dividend;
                  r_reg    <= '0;
                  count    <= '0;
                  zero_div <= (divisor == '0);
                  state    <= S_CALC;
               end
            end
            S_CALC: begin
               if (zero_div) begin
                  quotient    <= DBZ_QUOTIENT;
                  remainder   <= q_reg;
                  div_by_zero <= 1'b1;
                  state       <= S_DONE;
               end else begin
                  r_reg <= r_next;
                  q_reg <= q_next;
                  count <= count + 5'd1;
                  if (count == 5'd31) begin
                     quotient    <= q_next;
                     remainder   <= r_next;
                     div_by_zero <= 1'b0;
                     state       <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider_32.sv
// Directed and randomized checks of seq_divider_32 against plain / and %.
module tb_seq_divider_32;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        div_by_zero;

   int errors = 0;
   int checks = 0;

   seq_divider_32 dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // one full transaction: accept, wait for the result, optional stall, handshake
   task automatic run_op(input logic [31:0] dvd, input logic [31:0] dvs,
                         input int stall, input bit pulse);
      int          lat;
      logic [31:0] eq;
      logic [31:0] er;
      logic        edbz;
      edbz = (dvs == 32'd0);
      eq   = edbz ? 32'hFFFF_FFFF : dvd / dvs;
      er   = edbz ? dvd : dvd % dvs;
      @(negedge clk);
      chk("in_ready_idle", {63'd0, in_ready}, 64'd1);
      dividend = dvd;
      divisor  = dvs;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      dividend = $urandom;
      divisor  = $urandom;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 100) begin
         if (pulse) begin
            in_valid = 1'($urandom_range(0, 1));
            dividend = $urandom;
            divisor  = $urandom;
         end
         @(posedge clk);
         #1;
         lat++;
      end
      in_valid = 1'b0;
      chk("latency", 64'(lat), edbz ? 64'd1 : 64'd32);
      chk("quotient", {32'd0, quotient}, {32'd0, eq});
      chk("remainder", {32'd0, remainder}, {32'd0, er});
      chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, edbz});
      repeat (stall) begin
         @(posedge clk);
         #1;
      end
      if (stall > 0) begin
         chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
         chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
         chk("stall_quotient", {32'd0, quotient}, {32'd0, eq});
         chk("stall_remainder", {32'd0, remainder}, {32'd0, er});
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("out_valid_after_take", {63'd0, out_valid}, 64'd0);
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] b;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      dividend  = '0;
      divisor   = '0;
      #1;
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
      chk("rst_quotient", {32'd0, quotient}, 64'd0);
      chk("rst_remainder", {32'd0, remainder}, 64'd0);
      chk("rst_dbz", {63'd0, div_by_zero}, 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("release_in_ready", {63'd0, in_ready}, 64'd1);

      run_op(32'd100, 32'd7, 0, 1'b0);
      run_op(32'hFFFF_FFFF, 32'h8000_0001, 0, 1'b0);
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
      run_op(32'hFFFF_FFFF, 32'd1, 0, 1'b0);
      run_op(32'd5, 32'd0, 0, 1'b0);
      run_op(32'd9, 32'd3, 0, 1'b0);
      run_op(32'd123456789, 32'd1000, 10, 1'b0);
      run_op(32'd77777, 32'd13, 0, 1'b1);
      run_op(32'd0, 32'd0, 10, 1'b1);

      // reset at iteration 15 of 1000/3, between edges
      @(negedge clk);
      dividend = 32'd1000;
      divisor  = 32'd3;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (15) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
      chk("abort_in_ready", {63'd0, in_ready}, 64'd0);
      chk("abort_quotient", {32'd0, quotient}, 64'd0);
      chk("abort_remainder", {32'd0, remainder}, 64'd0);
      chk("abort_dbz", {63'd0, div_by_zero}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("abort_release_in_ready", {63'd0, in_ready}, 64'd1);
      run_op(32'd1000, 32'd3, 0, 1'b0);

      for (int i = 0; i < 1200; i++) begin
         a = $urandom;
         b = $urandom;
         if ($urandom_range(0, 15) == 0) b = 32'd0;
         else if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
         run_op(a, b, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
